// File: rtl/poly_byte_decoder_if.sv
// Byte-stream input and coefficient-RAM write port of poly_byte_decoder.
// Both are grouped here so the decoder and its neighbours share one bundle.
interface poly_byte_decoder_if #(
  parameter int AW = 10
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [95:0]   ram_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, ram_wen, ram_waddr, ram_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_wen, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/poly_byte_decoder.sv
// Kyber ByteDecode/Decompress: byte stream in, 8 x 12-bit coefficient words out to RAM.
// Optional macro BYTE_DECODER_ABORT_EN adds an abort input that drops any running job.
module poly_byte_decoder #(
  parameter int Q    = 3329,
  parameter int AW   = 10,
  parameter int MAXW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    d_sel,
  input  logic [AW-1:0] base_addr,
  input  logic [6:0]    num_words,
`ifdef BYTE_DECODER_ABORT_EN
  input  logic          abort,
`endif
  poly_byte_decoder_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          range_err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

  state_t        state_reg;
  logic [3:0]    d_reg;
  logic [AW-1:0] base_reg;
  logic [6:0]    num_reg;
  logic [6:0]    word_cnt_reg;
  logic [3:0]    byte_cnt_reg;
  logic [95:0]   acc_reg;

  logic          s_ready_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          range_err_reg;
  logic          ram_wen_reg;
  logic [AW-1:0] ram_waddr_reg;
  logic [95:0]   ram_wdata_reg;

  logic [95:0]   acc_next;
  logic [95:0]   word_dec;
  logic [7:0]    coef_err;
  logic          start_ok;
  logic          last_byte;

  // Decoding works on the accumulator including the byte being accepted now,
  // so the decoded word can be registered straight into the WRITE cycle.
  assign acc_next  = acc_reg | (96'(bus.s_data) << {byte_cnt_reg, 3'b000});
  assign last_byte = (byte_cnt_reg == d_reg - 4'd1);

  assign start_ok = start && (num_words != 7'd0) && (num_words <= 7'(MAXW)) &&
                    ((d_sel == 4'd1) || (d_sel == 4'd4) ||
                     (d_sel == 4'd10) || (d_sel == 4'd12));

  function automatic logic [11:0] decompress(input logic [9:0] x, input int unsigned d);
    logic [23:0] p;
    p = 24'(x) * 24'(Q) + (24'd1 << (d - 1));
    return 12'(p >> d);
  endfunction

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_coef
      logic [11:0] coef;
      logic [11:0] raw12;

      assign raw12 = acc_next[12*gi +: 12];

      always_comb begin
        coef = raw12;
        case (d_reg)
          4'd1:    coef = decompress(10'(acc_next[gi]), 1);
          4'd4:    coef = decompress(10'(acc_next[4*gi +: 4]), 4);
          4'd10:   coef = decompress(acc_next[10*gi +: 10], 10);
          default: coef = raw12;
        endcase
      end

      assign word_dec[12*gi +: 12] = coef;
      assign coef_err[gi] = (d_reg == 4'd12) && (raw12 >= 12'(Q));
    end
  endgenerate

`ifdef BYTE_DECODER_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort && (state_reg != IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      d_reg         <= 4'd0;
      base_reg      <= '0;
      num_reg       <= 7'd0;
      word_cnt_reg  <= 7'd0;
      byte_cnt_reg  <= 4'd0;
      acc_reg       <= 96'd0;
      s_ready_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      range_err_reg <= 1'b0;
      ram_wen_reg   <= 1'b0;
      ram_waddr_reg <= '0;
      ram_wdata_reg <= 96'd0;
    end else begin
      done_reg      <= 1'b0;
      ram_wen_reg   <= 1'b0;
      ram_waddr_reg <= '0;
      ram_wdata_reg <= 96'd0;
`ifdef BYTE_DECODER_ABORT_EN
      if (abort_hit) begin
        state_reg    <= IDLE;
        s_ready_reg  <= 1'b0;
        busy_reg     <= 1'b0;
        acc_reg      <= 96'd0;
        byte_cnt_reg <= 4'd0;
        word_cnt_reg <= 7'd0;
      end else
`endif
      begin
        case (state_reg)
          IDLE: begin
            if (start_ok) begin
              d_reg         <= d_sel;
              base_reg      <= base_addr;
              num_reg       <= num_words;
              word_cnt_reg  <= 7'd0;
              byte_cnt_reg  <= 4'd0;
              acc_reg       <= 96'd0;
              range_err_reg <= 1'b0;
              s_ready_reg   <= 1'b1;
              busy_reg      <= 1'b1;
              state_reg     <= RECV;
            end
          end
          RECV: begin
            if (bus.s_valid) begin
              if (last_byte) begin
                state_reg     <= WRITE;
                s_ready_reg   <= 1'b0;
                ram_wen_reg   <= 1'b1;
                ram_waddr_reg <= base_reg + AW'(word_cnt_reg);
                ram_wdata_reg <= word_dec;
                acc_reg       <= 96'd0;
                byte_cnt_reg  <= 4'd0;
                if (|coef_err) range_err_reg <= 1'b1;
              end else begin
                acc_reg      <= acc_next;
                byte_cnt_reg <= byte_cnt_reg + 4'd1;
              end
            end
          end
          WRITE: begin
            word_cnt_reg <= word_cnt_reg + 7'd1;
            if (word_cnt_reg == num_reg - 7'd1) begin
              state_reg <= FIN;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= RECV;
              s_ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.s_ready = s_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign range_err   = range_err_reg;

`ifdef BYTE_DECODER_ABORT_EN
  // A word registered for WRITE is suppressed if abort lands in that same cycle.
  assign bus.ram_wen   = ram_wen_reg & ~abort_hit;
  assign bus.ram_waddr = abort_hit ? '0 : ram_waddr_reg;
  assign bus.ram_wdata = abort_hit ? 96'd0 : ram_wdata_reg;
`else
  assign bus.ram_wen   = ram_wen_reg;
  assign bus.ram_waddr = ram_waddr_reg;
  assign bus.ram_wdata = ram_wdata_reg;
`endif

endmodule
